// File: rtl/sser_pkg.sv
// Shared types and constants for the SSER write-side serializer.
package sser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_PARITY,
    ST_HOLD
  } state_t;

  localparam logic [3:0] CMD_LOAD  = 4'h0;
  localparam logic [3:0] CMD_START = 4'h1;
  localparam logic [3:0] CMD_ABORT = 4'h2;
  localparam logic [3:0] CMD_CLRO  = 4'h3;

  // ba[13:12] pattern selecting the serial write window
  localparam logic [1:0] WIN_BA_HI = 2'b01;

  function automatic logic win_hit(input logic sser_n, input logic [1:0] ba_hi,
                                   input logic br_w);
    return ~sser_n & (ba_hi == WIN_BA_HI) & ~br_w;
  endfunction

endpackage

// File: rtl/sser_wr_shifter_if.sv
// Host bus write side plus serial link outputs of the SSER write serializer.
interface sser_wr_shifter_if;
  logic        sser_n;
  logic [13:0] ba;
  logic        br_w;
  logic [7:0]  bd;
  logic        sdwr;
  logic        sdclk;
  logic        sdcs_n;
  logic        busy;
  logic        ovr;

  modport master (
    output sser_n, ba, br_w, bd,
    input  sdwr, sdclk, sdcs_n, busy, ovr
  );

  modport slave (
    input  sser_n, ba, br_w, bd,
    output sdwr, sdclk, sdcs_n, busy, ovr
  );
endinterface

// File: rtl/sser_bitclk.sv
// Half-bit divider: one-clock rise/fall strobes marking the ends of the
// low and high halves of each serial bit period.
module sser_bitclk #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam logic [7:0] LAST = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       phase_q, phase_d;
  logic       half_end;

  assign half_end   = en_i & ~clr_i & (cnt_q == LAST);
  assign rise_stb_o = half_end & ~phase_q;
  assign fall_stb_o = half_end & phase_q;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (clr_i) begin
      cnt_d   = 8'd0;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (cnt_q == LAST) begin
        cnt_d   = 8'd0;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 8'd0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/sser_wr_shifter.sv
// SSER bus-write serializer: captures host commands in the SSER window and
// shifts bytes out MSB-first. Define SSER_WR_PARITY_EN to append an even parity bit.
module sser_wr_shifter
  import sser_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             rst,
  sser_wr_shifter_if.slave sif
);

  logic       hit, hit_q, accept;
  logic [3:0] cmd;
  logic       is_load, is_start, is_abort, is_clro;
  logic       rise_stb, fall_stb, bc_en, bc_clr;
  logic       unused_ba;

  state_t     state_q, state_d;
  logic [7:0] data_q, data_d;
  logic [7:0] shreg_q, shreg_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       sdwr_q, sdwr_d;
  logic       sdclk_q, sdclk_d;
  logic       sdcs_n_q, sdcs_n_d;
  logic       busy_q, busy_d;
  logic       ovr_q, ovr_d;
`ifdef SSER_WR_PARITY_EN
  logic       par_q, par_d;
`endif

  assign hit       = win_hit(sif.sser_n, sif.ba[13:12], sif.br_w);
  assign accept    = hit & ~hit_q;
  assign cmd       = sif.ba[7:4];
  assign is_load   = accept & (cmd == CMD_LOAD);
  assign is_start  = accept & (cmd == CMD_START);
  assign is_abort  = accept & (cmd == CMD_ABORT);
  assign is_clro   = accept & (cmd == CMD_CLRO);
  assign unused_ba = ^{sif.ba[11:8], sif.ba[3:0]};

  // Divider free-runs only inside a frame so every frame starts phase-aligned
  assign bc_en  = (state_q != ST_IDLE);
  assign bc_clr = (state_q == ST_IDLE) | is_abort;

  sser_bitclk #(.CLK_DIV(CLK_DIV)) u_bitclk (
    .clk       (clk),
    .rst       (rst),
    .en_i      (bc_en),
    .clr_i     (bc_clr),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    sdwr_d   = sdwr_q;
    sdclk_d  = sdclk_q;
    sdcs_n_d = sdcs_n_q;
    busy_d   = busy_q;
    ovr_d    = ovr_q;
`ifdef SSER_WR_PARITY_EN
    par_d    = par_q;
`endif

    if (is_clro) begin
      ovr_d = 1'b0;
    end else if ((is_load | is_start) & busy_q) begin
      ovr_d = 1'b1;
    end
    if (is_load & ~busy_q) begin
      data_d = sif.bd;
    end

    if (is_abort & (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      sdwr_d   = 1'b0;
      sdclk_d  = 1'b0;
      sdcs_n_d = 1'b1;
      busy_d   = 1'b0;
      bitcnt_d = 3'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (is_start) begin
            state_d  = ST_SETUP;
            sdcs_n_d = 1'b0;
            busy_d   = 1'b1;
            shreg_d  = data_q;
            sdwr_d   = data_q[7];
            bitcnt_d = 3'd0;
`ifdef SSER_WR_PARITY_EN
            par_d    = ^data_q;
`endif
          end
        end
        ST_SETUP: begin
          if (fall_stb) state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          if (rise_stb) sdclk_d = 1'b1;
          if (fall_stb) begin
            sdclk_d = 1'b0;
            if (bitcnt_q == 3'd7) begin
              bitcnt_d = 3'd0;
`ifdef SSER_WR_PARITY_EN
              state_d  = ST_PARITY;
              sdwr_d   = par_q;
`else
              state_d  = ST_HOLD;
              sdwr_d   = 1'b0;
`endif
            end else begin
              bitcnt_d = bitcnt_q + 3'd1;
              shreg_d  = shreg_q << 1;
              sdwr_d   = shreg_q[6];
            end
          end
        end
`ifdef SSER_WR_PARITY_EN
        ST_PARITY: begin
          if (rise_stb) sdclk_d = 1'b1;
          if (fall_stb) begin
            sdclk_d = 1'b0;
            state_d = ST_HOLD;
            sdwr_d  = 1'b0;
          end
        end
`endif
        ST_HOLD: begin
          if (fall_stb) begin
            state_d  = ST_IDLE;
            sdcs_n_d = 1'b1;
            busy_d   = 1'b0;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          sdwr_d   = 1'b0;
          sdclk_d  = 1'b0;
          sdcs_n_d = 1'b1;
          busy_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q    <= 1'b0;
      state_q  <= ST_IDLE;
      data_q   <= 8'h00;
      shreg_q  <= 8'h00;
      bitcnt_q <= 3'd0;
      sdwr_q   <= 1'b0;
      sdclk_q  <= 1'b0;
      sdcs_n_q <= 1'b1;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef SSER_WR_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      hit_q    <= hit;
      state_q  <= state_d;
      data_q   <= data_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      sdwr_q   <= sdwr_d;
      sdclk_q  <= sdclk_d;
      sdcs_n_q <= sdcs_n_d;
      busy_q   <= busy_d;
      ovr_q    <= ovr_d;
`ifdef SSER_WR_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  assign sif.sdwr   = sdwr_q;
  assign sif.sdclk  = sdclk_q;
  assign sif.sdcs_n = sdcs_n_q;
  assign sif.busy   = busy_q;
  assign sif.ovr    = ovr_q;

endmodule

// File: doc/sser_wr_shifter.md
# sser_wr_shifter

Bus-write serializer for the SSER serial port window. It captures bytes and commands written by the host into the SSER address window (SSER low, BA13=0, BA12=1, BR_W low). It shifts each byte out MSB-first on a chip-select-framed serial link, with a generated serial clock. It is the transmit/write counterpart of the existing SSER read-side sequencer, which drives SDRD on bus reads in the same window.

## Interface
- `CLK_DIV`, default 4: system clocks per serial half-bit. Legal range is 1..255.
- `clk`  in  1  system clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `sser_n`  in  1  serial-port select, active low
- `ba`  in  14  bus address `[13:0]`; only `ba[13:12]` and `ba[7:4]` are decoded
- `br_w`  in  1  bus read/write; 1=read, 0=write
- `bd`  in  8  bus write data
- `sdwr`  out  1  serial data out
- `sdclk`  out  1  serial clock; idles low
- `sdcs_n`  out  1  serial chip select, active low
- `busy`  out  1  frame in progress
- `ovr`  out  1  sticky overrun flag

## Operation
- **Window hit**: `hit = ~sser_n & ~ba[13] & ba[12] & ~br_w`.
- **Write accept**: an access is accepted only on the first `clk` where `hit` rises (previous-cycle `hit` was 0). A bus cycle held for N clocks therefore acts exactly once. Read cycles (`br_w=1`) are ignored entirely.
- **Commands**, selected by `ba[7:4]`:
  - 0x0 LOAD: `data_reg <= bd`.
  - 0x1 START: begin a frame using `data_reg`.
  - 0x2 ABORT: end any frame.
  - 0x3 CLRO: clear `ovr`.
  - All other codes: no effect.
- **Writes while busy**:
  - LOAD or START while `busy`: ignored, and `ovr <= 1`.
  - ABORT and CLRO are always honoured.
- **FSM states**: IDLE, SETUP, SHIFT, [PARITY], HOLD.
  - IDLE → SETUP on an accepted START. `sdcs_n` falls and `busy` rises in the same edge. The shift register is loaded from `data_reg`, and `sdwr` = bit 7.
  - SETUP lasts 1 bit period; `sdclk` stays low.
  - SHIFT sends 8 bit periods. Each bit period is `CLK_DIV` clocks with `sdclk` low, then `CLK_DIV` clocks with `sdclk` high. `sdwr` changes only at bit-period start, i.e. on the `sdclk` falling edge or at SHIFT entry. The receiver samples on `sdclk` rising.
  - HOLD lasts 1 bit period with `sdclk` low and `sdwr` low.
  - HOLD → IDLE: `sdcs_n` goes high and `busy` goes low on the same edge.
- **ABORT in any non-IDLE state**: go to IDLE on the next edge, with `sdcs_n`=1, `sdclk`=0, `sdwr`=0, `busy`=0. `data_reg` is kept. ABORT in IDLE is a no-op.
- **Simultaneous events**: a START accepted on the same edge that HOLD→IDLE completes is treated as busy: it is ignored and sets `ovr`.
- **Counters**:
  - Half-bit counter is 8 bits and wraps to 0 at `CLK_DIV-1`.
  - Bit counter is 3 bits and wraps 7→0 at SHIFT exit.

## Timing
- **Reset values** (`rst` high at any point, including mid-frame): `sdwr`=0, `sdclk`=0, `sdcs_n`=1, `busy`=0, `ovr`=0, `data_reg`=0x00, FSM=IDLE, edge detector=0. Reset takes effect on the next edge.
- **Latency**: accepted START → `sdcs_n` low after 1 clk.
- **Frame length**: 10 bit periods = `20*CLK_DIV` clocks of `busy`, or 11 bit periods with parity.
- **Early use**: a LOAD followed by START on the very next clk is legal; the new byte is sent.

## Configuration
- Macro `SSER_WR_PARITY_EN`.
- **Defined**: a PARITY state is inserted between SHIFT and HOLD. It lasts one full bit period with the normal `sdclk` pulse and sends even parity, `sdwr = ^data`.
- **Undefined**: there is no PARITY state; SHIFT goes directly to HOLD.

## Structure
- **Package `sser_pkg`**:
  - FSM state enum.
  - Command codes: `CMD_LOAD`, `CMD_START`, `CMD_ABORT`, `CMD_CLRO`.
  - Window decode constants for `ba[13:12]`.
- **Sub-module `sser_bitclk`**:
  - Half-bit divider with enable, synchronous clear, and `CLK_DIV` parameter.
  - Emits one-clock `rise_stb` and `fall_stb` pulses.
  - The FSM and `sdclk` logic are driven from these strobes.

## Test plan
- LOAD 0xA5, then START, `CLK_DIV`=2: the bits sampled on `sdclk` rising are 1,0,1,0,0,1,0,1. `busy` is high for exactly 40 clks, and `sdcs_n` is low for the same window.
- With `SSER_WR_PARITY_EN`: 0xA5 gives a parity bit of 0 and 0x07 gives 1. `busy` is 44 clks at `CLK_DIV`=2.
- LOAD 0x3C during a frame: the frame bits are unchanged and `ovr`=1. CLRO then sets `ovr`=0.
- ABORT on the 3rd `sdclk` rising: one clock later `sdcs_n`=1, `sdclk`=0, and `busy`=0. A following START resends `data_reg` from bit 7.
- `rst` pulsed mid-SHIFT: all outputs reach their reset values on the next edge, and `data_reg` reads 0x00 on the next START, i.e. eight 0 bits.
- Write START held for 5 clks produces one frame only. A read (`br_w`=1) with START address produces no frame and no `ovr`.
